// File: rtl/fsm_umbrales_pkg.sv
// Shared encodings for the FIFO threshold supervisor.
// State codes and counter width used by fsm_umbrales_n.
package fsm_umbrales_pkg;

  localparam int STATE_W = 3;
  localparam int CNT_W   = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/prio_enc_n.sv
// Lowest-index priority encoder.
// Returns the index of the lowest set request bit, 0 when none.
module prio_enc_n #(
  parameter int N    = 5,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    i_req,
  output logic [ID_W-1:0] o_id
);

  // scan from the top so the lowest set bit wins
  always_comb begin
    o_id = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_id = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/fsm_umbrales_n.sv
// Supervisor FSM for N FIFOs with threshold bank and error capture.
// Optional ERROR entry counter built when FSM_ERROR_COUNT_EN is defined.
module fsm_umbrales_n
  import fsm_umbrales_pkg::*;
#(
  parameter int  NUM_FIFOS = 5,
  parameter int  UMBRAL_W  = 4,
  localparam int ID_W      = $clog2(NUM_FIFOS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          init,
  input  logic [NUM_FIFOS*UMBRAL_W-1:0] umbrales_in,
  input  logic [NUM_FIFOS-1:0]          fifo_empty,
  input  logic [NUM_FIFOS-1:0]          fifo_error,
  output logic [NUM_FIFOS*UMBRAL_W-1:0] umbral_out,
  output logic                          idle_out,
  output logic                          active_out,
  output logic                          error_out,
  output logic [2:0]                    state_out,
  output logic [ID_W-1:0]               error_fifo_id,
  output logic [NUM_FIFOS-1:0]          error_mask,
  output logic [7:0]                    err_count
);

  state_t                        r_state;
  state_t                        w_next;
  logic                          w_any_err;
  logic                          w_all_empty;
  logic                          w_enter_err;
  logic                          w_load_umb;
  logic [ID_W-1:0]               w_prio_id;
  logic [NUM_FIFOS*UMBRAL_W-1:0] r_umbral;
  logic [ID_W-1:0]               r_err_id;
  logic [NUM_FIFOS-1:0]          r_err_mask;

  assign w_any_err   = |fifo_error;
  assign w_all_empty = &fifo_empty;

  prio_enc_n #(
    .N    (NUM_FIFOS),
    .ID_W (ID_W)
  ) u_prio (
    .i_req (fifo_error),
    .o_id  (w_prio_id)
  );

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RESET;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state; errors take priority over init
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_RESET: begin
        if (init) w_next = ST_INIT;
      end
      ST_INIT: begin
        if (w_any_err)  w_next = ST_ERROR;
        else if (!init) w_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (w_any_err)         w_next = ST_ERROR;
        else if (init)         w_next = ST_INIT;
        else if (!w_all_empty) w_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (w_any_err)        w_next = ST_ERROR;
        else if (init)        w_next = ST_INIT;
        else if (w_all_empty) w_next = ST_IDLE;
      end
      ST_ERROR: begin
        if (init) w_next = ST_INIT;
      end
      default: w_next = ST_RESET;
    endcase
  end

  assign w_enter_err = (w_next == ST_ERROR) && (r_state != ST_ERROR);

  // thresholds sampled on the edge into INIT and every edge spent in INIT
  assign w_load_umb = (r_state == ST_INIT) || (w_next == ST_INIT);

  // threshold bank
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_umbral <= '0;
    end else if (w_load_umb) begin
      r_umbral <= umbrales_in;
    end
  end

  // error source capture: first id on entry, mask accumulates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_id   <= '0;
      r_err_mask <= '0;
    end else if (w_enter_err) begin
      r_err_id   <= w_prio_id;
      r_err_mask <= fifo_error;
    end else if (r_state == ST_ERROR) begin
      if (w_next == ST_INIT) begin
        r_err_id   <= '0;
        r_err_mask <= '0;
      end else begin
        r_err_mask <= r_err_mask | fifo_error;
      end
    end
  end

`ifdef FSM_ERROR_COUNT_EN
  logic [CNT_W-1:0] r_err_cnt;

  // saturating count of ERROR entries, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_cnt <= '0;
    end else if (w_enter_err && (r_err_cnt != CNT_MAX)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign err_count = r_err_cnt;
`else
  assign err_count = '0;
`endif

  assign umbral_out    = r_umbral;
  assign error_fifo_id = r_err_id;
  assign error_mask    = r_err_mask;
  assign state_out     = r_state;
  assign idle_out      = (r_state == ST_IDLE);
  assign active_out    = (r_state == ST_ACTIVE);
  assign error_out     = (r_state == ST_ERROR);

endmodule

// File: tb/tb_fsm_umbrales_n.sv
// Bench for fsm_umbrales_n: directed scenarios plus random
// traffic checked against a behavioural model.
module tb_fsm_umbrales_n;

`ifdef FSM_ERROR_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        init;
  logic [19:0] umbrales_in;
  logic [4:0]  fifo_empty;
  logic [4:0]  fifo_error;
  logic [19:0] umbral_out;
  logic        idle_out;
  logic        active_out;
  logic        error_out;
  logic [2:0]  state_out;
  logic [2:0]  error_fifo_id;
  logic [4:0]  error_mask;
  logic [7:0]  err_count;

  int total = 0;
  int bad   = 0;

  int          m_st;
  logic [19:0] m_umb;
  int          m_id;
  logic [4:0]  m_mask;
  int          m_cnt;

  fsm_umbrales_n #(
    .NUM_FIFOS (5),
    .UMBRAL_W  (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .init          (init),
    .umbrales_in   (umbrales_in),
    .fifo_empty    (fifo_empty),
    .fifo_error    (fifo_error),
    .umbral_out    (umbral_out),
    .idle_out      (idle_out),
    .active_out    (active_out),
    .error_out     (error_out),
    .state_out     (state_out),
    .error_fifo_id (error_fifo_id),
    .error_mask    (error_mask),
    .err_count     (err_count)
  );

  always #5 clk = ~clk;

  wire [41:0] dut_vec = {state_out, idle_out, active_out, error_out,
                         error_fifo_id, error_mask, umbral_out, err_count};

  function automatic logic [41:0] exp_vec();
    logic [7:0] c;
    c = CNT_EN ? 8'(m_cnt) : 8'd0;
    return {3'(m_st), m_st == 2, m_st == 3, m_st == 4,
            3'(m_id), m_mask, m_umb, c};
  endfunction

  task automatic mdl_reset();
    m_st = 0; m_umb = '0; m_id = 0; m_mask = '0; m_cnt = 0;
  endtask

  // behavioural model: one clock of the specified rules
  task automatic mdl_step();
    bit any_err;
    bit all_emp;
    int nx;
    int low;
    any_err = (fifo_error != 0);
    all_emp = (fifo_empty == 5'h1f);
    nx = m_st;
    if (m_st == 0)
      nx = init ? 1 : 0;
    else if (m_st == 1)
      nx = any_err ? 4 : (init ? 1 : 2);
    else if (m_st == 2 || m_st == 3)
      nx = any_err ? 4 : (init ? 1 : (all_emp ? 2 : 3));
    else if (m_st == 4)
      nx = init ? 1 : 4;
    else
      nx = 0;
    if (m_st == 1 || nx == 1) m_umb = umbrales_in;
    if (nx == 4 && m_st != 4) begin
      low = 0;
      for (int i = 4; i >= 0; i--) if (fifo_error[i]) low = i;
      m_id = low;
      m_mask = fifo_error;
      if (m_cnt < 255) m_cnt++;
    end else if (m_st == 4 && nx == 1) begin
      m_id = 0;
      m_mask = '0;
    end else if (m_st == 4) begin
      m_mask = m_mask | fifo_error;
    end
    m_st = nx;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!reset) mdl_step();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; init = 1'b0;
    umbrales_in = 20'($urandom);
    fifo_empty = 5'($urandom); fifo_error = 5'($urandom);
    mdl_reset();
    for (int i = 0; i < 4; i++) begin
      cyc();
      total++;
      if (dut_vec !== 42'd0) begin
        bad++;
        $display("FAIL reset_hold cyc%0d got=%h want=0", i, dut_vec);
      end
    end
    reset = 1'b0;
    fifo_error = '0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++;
      if (state_out !== 3'd0 || idle_out !== 1'b0) begin
        bad++;
        $display("FAIL reset_stay cyc%0d state=%0d want=0", i, state_out);
      end
    end
  endtask

  task automatic test_init_load();
    logic [19:0] u;
    u = {4'd2, 4'd2, 4'd3, 4'd3, 4'd1};
    umbrales_in = u; fifo_empty = 5'h1f; fifo_error = '0;
    init = 1'b1;
    cyc();
    total++;
    if (state_out !== 3'd1 || umbral_out !== u) begin
      bad++;
      $display("FAIL init_load state=%0d umb=%h want 1 %h",
               state_out, umbral_out, u);
    end
    cyc();
    init = 1'b0;
    cyc();
    total++;
    if (idle_out !== 1'b1 || state_out !== 3'd2 || umbral_out !== u) begin
      bad++;
      $display("FAIL init_to_idle idle=%b state=%0d umb=%h want 1 2 %h",
               idle_out, state_out, umbral_out, u);
    end
  endtask

  task automatic test_active();
    fifo_empty = 5'b11101;
    cyc();
    total++;
    if (active_out !== 1'b1 || idle_out !== 1'b0 || state_out !== 3'd3) begin
      bad++;
      $display("FAIL to_active act=%b state=%0d want 1 3",
               active_out, state_out);
    end
    fifo_empty = 5'h1f;
    cyc();
    total++;
    if (idle_out !== 1'b1 || state_out !== 3'd2) begin
      bad++;
      $display("FAIL to_idle idle=%b state=%0d want 1 2",
               idle_out, state_out);
    end
    fifo_empty = 5'b01111;
    cyc();
  endtask

  task automatic test_error();
    fifo_error = 5'b01100;
    cyc();
    fifo_error = '0;
    total++;
    if (error_out !== 1'b1 || error_fifo_id !== 3'd2 ||
        error_mask !== 5'b01100 || err_count !== (CNT_EN ? 8'd1 : 8'd0)) begin
      bad++;
      $display("FAIL err_entry err=%b id=%0d mask=%b cnt=%0d want 1 2 01100",
               error_out, error_fifo_id, error_mask, err_count);
    end
    cyc();
    fifo_error = 5'b10000;
    cyc();
    fifo_error = '0;
    total++;
    if (error_mask !== 5'b11100 || error_fifo_id !== 3'd2) begin
      bad++;
      $display("FAIL err_accum mask=%b id=%0d want 11100 2",
               error_mask, error_fifo_id);
    end
    for (int i = 0; i < 3; i++) begin
      fifo_empty = (i % 2 == 0) ? 5'h1f : 5'h00;
      cyc();
      total++;
      if (state_out !== 3'd4 || error_out !== 1'b1) begin
        bad++;
        $display("FAIL err_hold cyc%0d state=%0d want 4", i, state_out);
      end
    end
  endtask

  task automatic test_reinit();
    umbrales_in = 20'hFFFFF;
    fifo_empty = 5'h1f;
    fifo_error = 5'b00010;
    init = 1'b1;
    cyc();
    fifo_error = '0;
    total++;
    if (state_out !== 3'd1 || error_out !== 1'b0 || error_mask !== 5'd0 ||
        error_fifo_id !== 3'd0 || umbral_out !== 20'hFFFFF) begin
      bad++;
      $display("FAIL reinit state=%0d err=%b mask=%b id=%0d umb=%h",
               state_out, error_out, error_mask, error_fifo_id, umbral_out);
    end
    init = 1'b0;
    cyc();
    total++;
    if (idle_out !== 1'b1 || state_out !== 3'd2) begin
      bad++;
      $display("FAIL reinit_idle state=%0d want 2", state_out);
    end
  endtask

  task automatic test_err_count();
    fifo_error = 5'b00001;
    cyc();
    fifo_error = '0;
    total++;
    if (state_out !== 3'd4 || error_fifo_id !== 3'd0) begin
      bad++;
      $display("FAIL err2_entry state=%0d id=%0d want 4 0",
               state_out, error_fifo_id);
    end
    init = 1'b1;
    cyc();
    init = 1'b0;
    cyc();
    total++;
    if (err_count !== (CNT_EN ? 8'd2 : 8'd0) || state_out !== 3'd2) begin
      bad++;
      $display("FAIL err_count cnt=%0d state=%0d want %0d 2",
               err_count, state_out, CNT_EN ? 2 : 0);
    end
  endtask

  task automatic test_async_reset();
    fifo_empty = 5'b10111;
    cyc();
    total++;
    if (state_out !== 3'd3) begin
      bad++;
      $display("FAIL pre_async state=%0d want 3", state_out);
    end
    #2;
    reset = 1'b1;
    #1;
    mdl_reset();
    total++;
    if (dut_vec !== 42'd0) begin
      bad++;
      $display("FAIL async_reset got=%h want=0", dut_vec);
    end
    cyc();
    reset = 1'b0;
    fifo_empty = 5'h1f;
  endtask

  task automatic test_saturation();
    fifo_empty = 5'h1f;
    init = 1'b1; fifo_error = '0;
    cyc();
    for (int i = 0; i < 262; i++) begin
      init = 1'b0; fifo_error = 5'b01000;
      cyc();
      init = 1'b1; fifo_error = '0;
      cyc();
    end
    init = 1'b0;
    cyc();
    total++;
    if (err_count !== (CNT_EN ? 8'd255 : 8'd0) || dut_vec !== exp_vec()) begin
      bad++;
      $display("FAIL saturate cnt=%0d got=%h model=%h",
               err_count, dut_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 600; i++) begin
      init = ($urandom_range(0, 7) == 0);
      fifo_error = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd0;
      fifo_empty = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'h1f;
      umbrales_in = 20'($urandom);
      cyc();
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++;
        if (errs < 10)
          $display("FAIL random cyc%0d got=%h model=%h", i, dut_vec, exp_vec());
        errs++;
      end
    end
  endtask

  initial begin
    reset = 1'b1; init = 1'b0;
    umbrales_in = '0; fifo_empty = 5'h1f; fifo_error = '0;
    mdl_reset();
    test_reset();
    test_init_load();
    test_active();
    test_error();
    test_reinit();
    test_err_count();
    test_async_reset();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fsm_umbrales_n.md
# fsm_umbrales_n

Parametrised control state machine for the PCIe transmission-layer datapath. It supervises N FIFOs (main, VC and D stages) from their status flags and distributes programmable almost-full thresholds to them. It reports idle/active/error status, adds error-source identification, and allows re-initialisation out of ERROR without a reset. It sits beside the FIFO array inside `full_logic`-class top levels.

## Interface
- `NUM_FIFOS`, 5, number of supervised FIFOs (≥2)
- `UMBRAL_W`, 4, width of one threshold
- `ID_W`, `$clog2(NUM_FIFOS)`, width of FIFO index (derived localparam)

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `init`  in  1  request (re)initialisation / threshold load
- `umbrales_in`  in  NUM_FIFOS*UMBRAL_W  thresholds; FIFO i at bits [i*UMBRAL_W +: UMBRAL_W]
- `fifo_empty`  in  NUM_FIFOS  empty flag per FIFO
- `fifo_error`  in  NUM_FIFOS  overflow/underflow error per FIFO (level or pulse)
- `umbral_out`  out  NUM_FIFOS*UMBRAL_W  registered thresholds, same packing
- `idle_out`  out  1  state is IDLE
- `active_out`  out  1  state is ACTIVE
- `error_out`  out  1  state is ERROR
- `state_out`  out  3  current state code
- `error_fifo_id`  out  ID_W  lowest-index FIFO that caused entry to ERROR
- `error_mask`  out  NUM_FIFOS  accumulated error sources while in ERROR
- `err_count`  out  8  ERROR entries since reset (see Configuration)

## Operation
- States: RESET(0), INIT(1), IDLE(2), ACTIVE(3), ERROR(4); codes 5–7 go to RESET on the next clock.
- `any_err` = OR of `fifo_error`; `all_empty` = AND of `fifo_empty`.
- RESET: `init`=1 → INIT, otherwise stay.
- INIT: `umbral_out` ← `umbrales_in` every cycle. Transitions: `any_err` → ERROR; else `init`=0 → IDLE.
- IDLE: `any_err` → ERROR; else `init` → INIT; else `!all_empty` → ACTIVE.
- ACTIVE: `any_err` → ERROR; else `init` → INIT; else `all_empty` → IDLE.
- ERROR: `init`=1 → INIT, regardless of `fifo_error`; otherwise stay. `fifo_empty` is ignored in ERROR.
- On entry to ERROR: `error_fifo_id` ← lowest set index of `fifo_error`, and `error_mask` ← `fifo_error`.
- While in ERROR: `error_mask` |= `fifo_error`; `error_fifo_id` holds.
- Leaving ERROR to INIT clears `error_mask` and `error_fifo_id` to 0.
- `umbral_out` holds its value outside INIT. Values are passed unmodified; 0 is legal.

## Timing
- Moore outputs, all registered. An input sampled at edge n is reflected in the outputs after edge n; outputs are therefore 1 cycle late relative to when the input was presented.
- Thresholds presented during INIT at edge n appear on `umbral_out` after edge n.
- `reset` asserted at any time, including mid-ACTIVE or mid-INIT: state goes to RESET immediately, without waiting for a clock. All outputs go to 0, including `umbral_out`, `error_mask`, `error_fifo_id` and `err_count`.
- Exactly one of `idle_out`, `active_out`, `error_out` is high in IDLE, ACTIVE or ERROR. All three are 0 in RESET and INIT.
- A simultaneous `fifo_error` and `init` in IDLE, ACTIVE or INIT resolves to ERROR.

## Configuration
- `FSM_ERROR_COUNT_EN` defined: `err_count` increments on every transition into ERROR and saturates at 255. It is cleared only by `reset`, not by `init`.
- `FSM_ERROR_COUNT_EN` undefined: no counter logic is built; `err_count` is tied to 0.

## Structure
- Package `fsm_umbrales_pkg`: state encoding constants (ST_RESET … ST_ERROR), state width (3), counter width (8).
- Sub-module `prio_enc_n`: parametrised lowest-index priority encoder, `NUM_FIFOS` → `ID_W`, used for `error_fifo_id`.
- The threshold register bank stays in the top module.

## Test plan
- Reset held high for 4 cycles → all outputs 0, `state_out`=0. Then deassert with `init`=0 for 3 cycles → stays RESET.
- `init`=1 for 2 cycles with `umbrales_in`={4'd2,4'd2,4'd3,4'd3,4'd1}, then `init`=0 with `fifo_empty`=5'b11111 → `umbral_out` matches one cycle after first load; `idle_out`=1 one cycle after `init` falls.
- From IDLE, `fifo_empty`=5'b11101 → `active_out`=1 next cycle. Then `fifo_empty`=5'b11111 → `idle_out`=1 next cycle.
- In ACTIVE, `fifo_error`=5'b01100 for 1 cycle → `error_out`=1, `error_fifo_id`=2, `error_mask`=5'b01100. Later `fifo_error`=5'b10000 → `error_mask`=5'b11100, id stays 2. Toggling `fifo_empty` → no state change.
- In ERROR, `init`=1 with `umbrales_in` all 4'hF → `state_out`=1 next cycle; `error_out`, `error_mask` and `error_fifo_id` are 0; `umbral_out` is all F. Then `init`=0 → IDLE.
- With `FSM_ERROR_COUNT_EN`: two ERROR entries → `err_count`=2, and it survives re-init. Asserting `reset` between clock edges in ACTIVE → all outputs 0 immediately, `err_count`=0. Without the macro, `err_count` stays 0 throughout.
